seq_bcd_converter: RTL and testbench



---
 rtl/debug7sd_pkg.sv | 20 ++
 rtl/bcd_dabble_step.sv | 25 ++
 rtl/seq_bcd_converter.sv | 95 +++++++++
 tb/tb_seq_bcd_converter.sv | 357 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/debug7sd_pkg.sv
// Shared types and helpers for the seven-segment debug chain.
// Holds the converter state encoding and the decimal limit function.
package debug7sd_pkg;

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  // 10**digits, wide enough for eight digits without truncation
  function automatic logic [63:0] bcd_limit(input int digits);
    logic [63:0] r;
    r = 64'd1;
    for (int i = 0; i < digits; i++) begin
      r = r * 64'd10;
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd_dabble_step.sv
// One double-dabble iteration: add 3 to each nibble >= 5,
// then shift left by one, pulling bit_in into the LSB.
module bcd_dabble_step #(
  parameter int DIGITS = 4
) (
  input  logic [4*DIGITS-1:0] scratch_in,
  input  logic                bit_in,
  output logic [4*DIGITS-1:0] scratch_out
);

  logic [4*DIGITS-1:0] adj;

  // per-nibble correction, wrapping inside the nibble
  always_comb begin
    adj = scratch_in;
    for (int i = 0; i < DIGITS; i++) begin
      if (scratch_in[4*i+:4] >= 4'd5) begin
        adj[4*i+:4] = scratch_in[4*i+:4] + 4'd3;
      end
    end
  end

  assign scratch_out = {adj[4*DIGITS-2:0], bit_in};

endmodule

// File: rtl/seq_bcd_converter.sv
// Bit-serial binary-to-BCD converter feeding the debug display.
// Accepts one value per handshake, returns packed BCD after IN_WIDTH steps.
module seq_bcd_converter
  import debug7sd_pkg::*;
#(
  parameter int IN_WIDTH = 16,
  parameter int DIGITS   = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [IN_WIDTH-1:0] in_data,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [4*DIGITS-1:0] bcd_out,
  output logic                overflow,
  output logic                done
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(IN_WIDTH);
  localparam int TW = (IN_WIDTH > 34) ? IN_WIDTH : 34;
  localparam logic [TW-1:0] LIMIT = TW'(bcd_limit(DIGITS));

  state_t                stateQ;
  state_t                stateD;
  logic [IN_WIDTH-1:0]   shiftReg;
  logic [BW-1:0]         scratch;
  logic [BW-1:0]         stepOut;
  logic [CW-1:0]         bitCnt;
  logic                  ovfCap;
  logic                  ovfIn;

  assign ovfIn = (TW'(in_data) >= LIMIT);

  bcd_dabble_step #(
    .DIGITS(DIGITS)
  ) uStep (
    .scratch_in (scratch),
    .bit_in     (shiftReg[IN_WIDTH-1]),
    .scratch_out(stepOut)
  );

  // state register
  always_ff @(posedge clk) begin
    if (rst) stateQ <= IDLE;
    else     stateQ <= stateD;
  end

  // next state and handshake ready
  always_comb begin
    stateD   = stateQ;
    in_ready = 1'b0;
    unique case (stateQ)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) stateD = SHIFT;
      end
      SHIFT: begin
        if (bitCnt == '0) stateD = IDLE;
      end
      default: stateD = IDLE;
    endcase
  end

  // conversion datapath and held result
  always_ff @(posedge clk) begin
    if (rst) begin
      shiftReg <= '0;
      scratch  <= '0;
      bitCnt   <= '0;
      ovfCap   <= 1'b0;
      bcd_out  <= '0;
      overflow <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (stateQ == IDLE && in_valid) begin
        shiftReg <= in_data;
        scratch  <= '0;
        bitCnt   <= CW'(IN_WIDTH - 1);
        ovfCap   <= ovfIn;
      end else if (stateQ == SHIFT) begin
        scratch  <= stepOut;
        shiftReg <= {shiftReg[IN_WIDTH-2:0], 1'b0};
        bitCnt   <= bitCnt - CW'(1);
        if (bitCnt == '0) begin
          bcd_out  <= ovfCap ? '1 : stepOut;
          overflow <= ovfCap;
          done     <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_seq_bcd_converter.sv
// Self-checking bench for seq_bcd_converter.
// Scoreboard of reference conversions, compared at each done pulse.
module tb_seq_bcd_converter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] bcd_out;
  logic        overflow;
  logic        done;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  logic [16:0] expq[$];

  seq_bcd_converter #(
    .IN_WIDTH(16),
    .DIGITS  (4)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .in_data (in_data),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .bcd_out (bcd_out),
    .overflow(overflow),
    .done    (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [16:0] ref_model(input int unsigned v);
    logic [15:0] b;
    int unsigned t;
    if (v >= 10000) return {1'b1, 16'hFFFF};
    b = '0;
    t = v;
    for (int i = 0; i < 4; i++) begin
      b[4*i+:4] = 4'(t % 10);
      t = t / 10;
    end
    return {1'b0, b};
  endfunction

  task automatic wait_ready;
    for (int i = 0; i < 40; i++) begin
      if (in_ready) break;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive_accept(input logic [15:0] v, input bit keep,
                              output int ok);
    wait_ready();
    in_data  = v;
    in_valid = 1'b1;
    ok = int'(in_ready);
    if (ok == 1 && keep) expq.push_back(ref_model(v));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    in_valid = 1'b1;
    in_data = 16'd1234;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    in_valid = 1'b0;
    total++;
    if (bcd_out !== 16'h0000) begin
      bad++;
      $display("FAIL reset_bcd got=%h exp=0000", bcd_out);
    end
    total++;
    if (overflow !== 1'b0) begin
      bad++;
      $display("FAIL reset_ovf got=%b exp=0", overflow);
    end
    total++;
    if (done !== 1'b0) begin
      bad++;
      $display("FAIL reset_done got=%b exp=0", done);
    end
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_ready got=%b exp=1", in_ready);
    end
  endtask

  task automatic test_single;
    int ok;
    int busyBad = 0;
    int early = 0;
    logic [16:0] e;
    drive_accept(16'd1234, 1'b1, ok);
    total++;
    if (ok !== 1) begin
      bad++;
      $display("FAIL single_accept got=%0d exp=1", ok);
    end
    for (int k = 1; k <= 16; k++) begin
      @(posedge clk);
      #1;
      if (k < 16) begin
        if (in_ready) busyBad++;
        if (done) early++;
      end
    end
    total++;
    if (busyBad != 0) begin
      bad++;
      $display("FAIL single_busy got=%0d exp=0", busyBad);
    end
    total++;
    if (early != 0) begin
      bad++;
      $display("FAIL single_early got=%0d exp=0", early);
    end
    total++;
    if (done !== 1'b1) begin
      bad++;
      $display("FAIL single_done got=%b exp=1", done);
    end
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL single_ready got=%b exp=1", in_ready);
    end
    e = (expq.size() != 0) ? expq.pop_front() : 17'h1DEAD;
    total++;
    if ({overflow, bcd_out} !== e) begin
      bad++;
      $display("FAIL single_val got=%h exp=%h", {overflow, bcd_out}, e);
    end
    @(posedge clk);
    #1;
    total++;
    if (done !== 1'b0) begin
      bad++;
      $display("FAIL single_pulse got=%b exp=0", done);
    end
    total++;
    if ({overflow, bcd_out} !== e) begin
      bad++;
      $display("FAIL single_hold got=%h exp=%h", {overflow, bcd_out}, e);
    end
  endtask

  task automatic test_boundary;
    logic [15:0] vals[4];
    int ok;
    int lat;
    logic [16:0] e;
    vals = '{16'd9999, 16'd10000, 16'd65535, 16'd0};
    foreach (vals[i]) begin
      drive_accept(vals[i], 1'b1, ok);
      wait_done(lat);
      total++;
      if (lat != 16) begin
        bad++;
        $display("FAIL bound_lat v=%0d got=%0d exp=16", vals[i], lat);
      end
      e = (expq.size() != 0) ? expq.pop_front() : 17'h1DEAD;
      total++;
      if ({overflow, bcd_out} !== e) begin
        bad++;
        $display("FAIL bound_val v=%0d got=%h exp=%h",
                 vals[i], {overflow, bcd_out}, e);
      end
    end
  endtask

  task automatic test_back_to_back;
    int acc[$];
    int nd = 0;
    logic [16:0] e;
    wait_ready();
    in_data = 16'd42;
    in_valid = 1'b1;
    for (int k = 0; k < 45; k++) begin
      logic hs;
      hs = in_valid && in_ready;
      if (hs) begin
        acc.push_back(cyc);
        expq.push_back(ref_model(in_data));
      end
      @(posedge clk);
      #1;
      if (hs && acc.size() == 2) in_valid = 1'b0;
      if (acc.size() == 1)
        in_data = ((cyc - acc[0]) == 8) ? 16'd7777 : 16'd65535;
      if (done) begin
        nd++;
        e = (expq.size() != 0) ? expq.pop_front() : 17'h1DEAD;
        total++;
        if ({overflow, bcd_out} !== e) begin
          bad++;
          $display("FAIL b2b_val got=%h exp=%h", {overflow, bcd_out}, e);
        end
      end
    end
    in_valid = 1'b0;
    total++;
    if (acc.size() != 2) begin
      bad++;
      $display("FAIL b2b_accepts got=%0d exp=2", acc.size());
    end else begin
      total++;
      if (acc[1] - acc[0] != 17) begin
        bad++;
        $display("FAIL b2b_gap got=%0d exp=17", acc[1] - acc[0]);
      end
    end
    total++;
    if (nd != 2) begin
      bad++;
      $display("FAIL b2b_dones got=%0d exp=2", nd);
    end
    expq.delete();
  endtask

  task automatic test_reset_mid;
    int ok;
    int nd = 0;
    int lat;
    logic [16:0] e;
    drive_accept(16'd5678, 1'b0, ok);
    repeat (7) begin
      @(posedge clk);
      #1;
      if (done) nd++;
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    if (done) nd++;
    @(posedge clk);
    #1;
    rst = 1'b0;
    if (done) nd++;
    total++;
    if (bcd_out !== 16'h0000) begin
      bad++;
      $display("FAIL mid_bcd got=%h exp=0000", bcd_out);
    end
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL mid_ready got=%b exp=1", in_ready);
    end
    repeat (20) begin
      @(posedge clk);
      #1;
      if (done) nd++;
    end
    total++;
    if (nd != 0) begin
      bad++;
      $display("FAIL mid_nodone got=%0d exp=0", nd);
    end
    drive_accept(16'd5678, 1'b1, ok);
    wait_done(lat);
    total++;
    if (lat != 16) begin
      bad++;
      $display("FAIL mid_lat got=%0d exp=16", lat);
    end
    e = (expq.size() != 0) ? expq.pop_front() : 17'h1DEAD;
    total++;
    if ({overflow, bcd_out} !== e) begin
      bad++;
      $display("FAIL mid_val got=%h exp=%h", {overflow, bcd_out}, e);
    end
  endtask

  task automatic test_random;
    int accepted = 0;
    int dones = 0;
    int gap = 0;
    int iter = 0;
    logic [16:0] e;
    in_valid = 1'b0;
    while ((accepted < 2000 || expq.size() != 0) && iter < 60000) begin
      logic hs;
      iter++;
      if (!in_valid && accepted < 2000) begin
        if (gap == 0) begin
          if ($urandom_range(0, 7) == 0)
            in_data = 16'($urandom_range(9990, 10010));
          else
            in_data = 16'($urandom_range(0, 65535));
          in_valid = 1'b1;
        end else begin
          gap--;
        end
      end
      hs = in_valid && in_ready;
      if (hs) expq.push_back(ref_model(in_data));
      @(posedge clk);
      #1;
      if (hs) begin
        accepted++;
        in_valid = 1'b0;
        gap = $urandom_range(0, 3);
      end
      if (done) begin
        dones++;
        e = (expq.size() != 0) ? expq.pop_front() : 17'h1DEAD;
        total++;
        if ({overflow, bcd_out} !== e) begin
          bad++;
          $display("FAIL rand_val got=%h exp=%h", {overflow, bcd_out}, e);
        end
      end
    end
    total++;
    if (accepted != 2000 || dones != 2000) begin
      bad++;
      $display("FAIL rand_count got=%0d/%0d exp=2000/2000",
               accepted, dones);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_boundary();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
